// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction queue between fetch and dual-issue decode.
// The two oldest entries are read combinationally. Full is asserted with one free slot left so that a pair push never overflows.
module inst_fifo #(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inst_data_ok1,
    input  logic        inst_data_ok2,
    input  logic [31:0] inst_rdata1,
    input  logic [31:0] inst_rdata2,
    input  logic [31:0] pcF,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        empty,
    output logic        almost_empty,
    output logic        full
);

    localparam logic [PTR_WIDTH:0]   FULL_LVL = (PTR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]          inst_q [DEPTH];
    logic [31:0]          pc_q   [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q,  count_d;
    logic [PTR_WIDTH-1:0] wr_ptr_p1, rd_ptr_p1;
    logic [1:0]           push_n, pop_n;

    assign wr_ptr_p1 = wr_ptr_q + PTR_ONE;
    assign rd_ptr_p1 = rd_ptr_q + PTR_ONE;

    assign read_data1   = inst_q[rd_ptr_q];
    assign read_addr1   = pc_q[rd_ptr_q];
    assign read_data2   = inst_q[rd_ptr_p1];
    assign read_addr2   = pc_q[rd_ptr_p1];
    assign empty        = (count_q == {(PTR_WIDTH+1){1'b0}});
    assign almost_empty = (count_q == {{PTR_WIDTH{1'b0}}, 1'b1});
    assign full         = (count_q >= FULL_LVL);

    // Push/pop amounts; pops never exceed the number of entries held
    always_comb begin
        push_n = 2'd0;
        pop_n  = 2'd0;
        if (flush || full) begin
            push_n = 2'd0;
        end else if (inst_data_ok1 && inst_data_ok2) begin
            push_n = 2'd2;
        end else if (inst_data_ok1) begin
            push_n = 2'd1;
        end else begin
            push_n = 2'd0;
        end
        if (flush || !read_en1 || empty) begin
            pop_n = 2'd0;
        end else if (read_en2 && !almost_empty) begin
            pop_n = 2'd2;
        end else begin
            pop_n = 2'd1;
        end
    end

    // Next-state pointers and occupancy; flush returns everything to origin
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_WIDTH{1'b0}};
            rd_ptr_d = {PTR_WIDTH{1'b0}};
            count_d  = {(PTR_WIDTH+1){1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + {{(PTR_WIDTH-2){1'b0}}, push_n};
            rd_ptr_d = rd_ptr_q + {{(PTR_WIDTH-2){1'b0}}, pop_n};
            count_d  = count_q + {{(PTR_WIDTH-1){1'b0}}, push_n}
                               - {{(PTR_WIDTH-1){1'b0}}, pop_n};
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_WIDTH{1'b0}};
            rd_ptr_q <= {PTR_WIDTH{1'b0}};
            count_q  <= {(PTR_WIDTH+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; second slot carries pcF+4 at the wrapped index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
        end else if (push_n != 2'd0) begin
            inst_q[wr_ptr_q] <= inst_rdata1;
            pc_q[wr_ptr_q]   <= pcF;
            if (push_n == 2'd2) begin
                inst_q[wr_ptr_p1] <= inst_rdata2;
                pc_q[wr_ptr_p1]   <= pcF + 32'd4;
            end else begin
                inst_q[wr_ptr_p1] <= inst_q[wr_ptr_p1];
                pc_q[wr_ptr_p1]   <= pc_q[wr_ptr_p1];
            end
        end else begin
            inst_q[wr_ptr_q] <= inst_q[wr_ptr_q];
            pc_q[wr_ptr_q]   <= pc_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed vector table plus queue-model sequences for inst_fifo.
module tb_inst_fifo;

    logic        clk = 1'b0;
    logic        rst, flush, ok1, ok2, re1, re2;
    logic [31:0] d1, d2, pc;
    logic [31:0] rdata1, rdata2, raddr1, raddr2;
    logic        empty, almost_empty, full;

    int tests = 0;
    int fails = 0;
    logic [63:0] mq [$];

    always #5 clk = ~clk;

    inst_fifo #(.DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_data_ok1(ok1), .inst_data_ok2(ok2),
        .inst_rdata1(d1), .inst_rdata2(d2), .pcF(pc),
        .read_en1(re1), .read_en2(re2),
        .read_data1(rdata1), .read_data2(rdata2),
        .read_addr1(raddr1), .read_addr2(raddr2),
        .empty(empty), .almost_empty(almost_empty), .full(full)
    );

    typedef struct packed {
        logic        ok1, ok2;
        logic [31:0] d1, d2, pc;
        logic        re1, re2, fl;
        logic        e, ae, f;
        logic [31:0] rd1, ra1, rd2, ra2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a1, input logic a2, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [31:0] p, input logic r1, input logic r2,
                                input logic e, input logic ae,
                                input logic [31:0] rd1, input logic [31:0] ra1,
                                input logic [31:0] rd2, input logic [31:0] ra2);
        vec_t v;
        v.ok1 = a1; v.ok2 = a2; v.d1 = x1; v.d2 = x2; v.pc = p;
        v.re1 = r1; v.re2 = r2; v.fl = 1'b0;
        v.e = e; v.ae = ae; v.f = 1'b0;
        v.rd1 = rd1; v.ra1 = ra1; v.rd2 = rd2; v.ra2 = ra2;
        return v;
    endfunction

    // One clock of stimulus, reference queue update, then compare visible state
    task automatic step(input logic a1, input logic a2, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] p, input logic r1, input logic r2, input logic fl);
        int cnt, pushn, popn;
        ok1 = a1; ok2 = a2; d1 = x1; d2 = x2; pc = p; re1 = r1; re2 = r2; flush = fl;
        cnt   = mq.size();
        pushn = (fl || cnt >= 15) ? 0 : (a1 ? (a2 ? 2 : 1) : 0);
        popn  = fl ? 0 : ((r1 && cnt >= 1) ? 1 : 0) + ((r1 && r2 && cnt >= 2) ? 1 : 0);
        @(posedge clk); #1;
        if (fl) begin
            mq.delete();
        end else begin
            repeat (popn) void'(mq.pop_front());
            if (pushn >= 1) mq.push_back({x1, p});
            if (pushn == 2) mq.push_back({x2, p + 32'd4});
        end
        chk("m_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("m_aempty", {31'd0, almost_empty}, {31'd0, mq.size() == 1});
        chk("m_full", {31'd0, full}, {31'd0, mq.size() >= 15});
        if (mq.size() >= 1) begin
            chk("m_data1", rdata1, mq[0][63:32]);
            chk("m_addr1", raddr1, mq[0][31:0]);
        end
        if (mq.size() >= 2) begin
            chk("m_data2", rdata2, mq[1][63:32]);
            chk("m_addr2", raddr2, mq[1][31:0]);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ok1 = 1'b0; ok2 = 1'b0; re1 = 1'b0; re2 = 1'b0;
        d1 = 32'd0; d2 = 32'd0; pc = 32'd0;

        vecs[0] = mk(1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'hBFC00000, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h11111111, 32'hBFC00000, 32'h22222222, 32'hBFC00004);
        vecs[1] = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1,
                     1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[2] = mk(1'b1, 1'b0, 32'hAAAA0001, 32'hAAAA0002, 32'h00001000, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'hAAAA0001, 32'h00001000, 32'h0, 32'h0);
        vecs[3] = mk(1'b0, 1'b1, 32'hBBBB0001, 32'hBBBB0002, 32'h00002000, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'hAAAA0001, 32'h00001000, 32'h0, 32'h0);
        vecs[4] = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1,
                     1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(1'b1, 1'b1, 32'hCCCC0001, 32'hCCCC0002, 32'hFFFFFFFC, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'hCCCC0001, 32'hFFFFFFFC, 32'hCCCC0002, 32'h00000000);
        vecs[6] = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1,
                     1'b0, 1'b0, 32'hCCCC0001, 32'hFFFFFFFC, 32'hCCCC0002, 32'h00000000);
        vecs[7] = mk(1'b1, 1'b0, 32'hDDDD0001, 32'hDDDD0002, 32'h00003000, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'hCCCC0002, 32'h00000000, 32'hDDDD0001, 32'h00003000);
        vecs[8] = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1,
                     1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[9] = mk(1'b1, 1'b1, 32'hEEEE0001, 32'hEEEE0002, 32'h00004000, 1'b1, 1'b1,
                     1'b0, 1'b0, 32'hEEEE0001, 32'h00004000, 32'hEEEE0002, 32'h00004004);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_aempty", {31'd0, almost_empty}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_data1", rdata1, 32'd0);
        chk("rst_addr2", raddr2, 32'd0);

        for (int i = 0; i < 10; i++) begin
            ok1 = vecs[i].ok1; ok2 = vecs[i].ok2; d1 = vecs[i].d1; d2 = vecs[i].d2;
            pc = vecs[i].pc; re1 = vecs[i].re1; re2 = vecs[i].re2; flush = vecs[i].fl;
            @(posedge clk); #1;
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].e});
            chk($sformatf("v%0d_aempty", i), {31'd0, almost_empty}, {31'd0, vecs[i].ae});
            chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, vecs[i].f});
            chk($sformatf("v%0d_data1", i), rdata1, vecs[i].rd1);
            chk($sformatf("v%0d_addr1", i), raddr1, vecs[i].ra1);
            chk($sformatf("v%0d_data2", i), rdata2, vecs[i].rd2);
            chk($sformatf("v%0d_addr2", i), raddr2, vecs[i].ra2);
        end

        // Fill to full from a flushed queue: one single then seven pairs gives 15
        mq = {64'h0, 64'h0};
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h50000000, 32'h0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b1, 32'h50000001 + 32'(2*i), 32'h50000002 + 32'(2*i),
                 32'h00010004 + 32'(8*i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 1'b1, 32'hDEAD0001, 32'hDEAD0002, 32'h0BAD0000, 1'b0, 1'b0, 1'b0);
        chk("full_drop", {31'd0, full}, 32'd1);
        step(1'b1, 1'b1, 32'hDEAD0003, 32'hDEAD0004, 32'h0BAD0010, 1'b1, 1'b0, 1'b0);
        chk("full_pop_release", {31'd0, full}, 32'd0);
        for (int i = 0; i < 20 && mq.size() != 0; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Mixed single/dual traffic that walks both pointers through 15 -> 0
        for (int i = 0; i < 40; i++) begin
            logic a1, a2, r1, r2;
            a1 = ($urandom_range(0, 2) != 0);
            a2 = ($urandom_range(0, 1) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            r2 = ($urandom_range(0, 1) != 0);
            step(a1, a2, $urandom, $urandom, $urandom & 32'hFFFFFFFC, r1, r2, 1'b0);
        end

        // Flush wins over a simultaneous push and pop
        for (int i = 0; i < 20 && mq.size() != 0; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h60000000 + 32'(i), 32'h61000000 + 32'(i),
                 32'h00020000 + 32'(8*i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count6", mq.size(), 32'd6);
        step(1'b1, 1'b1, 32'h77770001, 32'h77770002, 32'h00030000, 1'b1, 1'b0, 1'b1);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("flush_aempty", {31'd0, almost_empty}, 32'd0);
        step(1'b1, 1'b0, 32'h88880001, 32'h0, 32'h00040000, 1'b0, 1'b0, 1'b0);
        chk("post_flush_head", rdata1, 32'h88880001);

        // Reset mid-operation clears pointers and storage
        step(1'b1, 1'b1, 32'h99990001, 32'h99990002, 32'h00050000, 1'b0, 1'b0, 1'b0);
        ok1 = 1'b0; ok2 = 1'b0; re1 = 1'b0; re2 = 1'b0; flush = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mq.delete();
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_data1", rdata1, 32'd0);
        chk("mid_rst_addr1", raddr1, 32'd0);
        chk("mid_rst_data2", rdata2, 32'd0);
        chk("mid_rst_addr2", raddr2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
